// File: rtl/dram_cmd_issuer.sv
// dram_cmd_issuer: in-order DRAM command issue stage with a write-data FIFO and read-return tagging.
// Ports: clk, power_on_rst (sync, active-high); host_valid/host_ready/host_cmd/host_wdata accept
// commands; ba_cmd_pm gates issue per bank; command/write_data/valid carry issued commands;
// read_data/read_data_valid in, rd_valid/rd_data/rd_tag/rd_underflow out for tagged returns.
// Optional CMD_ISSUE_STATS_EN adds stat_wr_cnt, stat_rd_cnt, stat_stall_cnt.
module dram_cmd_issuer #(
    parameter int DEPTH      = 8,
    parameter int RTAG_DEPTH = 16,
    parameter int DQ_W       = 128
) (
    input  logic            clk,
    input  logic            power_on_rst,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic [33:0]     host_cmd,
    input  logic [DQ_W-1:0] host_wdata,
    input  logic [7:0]      ba_cmd_pm,
    output logic [33:0]     command,
    output logic [DQ_W-1:0] write_data,
    output logic            valid,
    input  logic [DQ_W-1:0] read_data,
    input  logic            read_data_valid,
    output logic            rd_valid,
    output logic [DQ_W-1:0] rd_data,
    output logic [27:0]     rd_tag,
    output logic            rd_underflow
`ifdef CMD_ISSUE_STATS_EN
    ,
    output logic [15:0]     stat_wr_cnt,
    output logic [15:0]     stat_rd_cnt,
    output logic [15:0]     stat_stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(RTAG_DEPTH);
    logic [33:0]     cmd_mem [DEPTH];
    logic [DQ_W-1:0] dat_mem [DEPTH];
    logic [27:0]     tag_mem [RTAG_DEPTH];
    logic [AW:0]     cwp, crp;
    logic [TW:0]     twp, trp;
    logic            cmd_full, cmd_empty, tag_full, tag_empty;
    logic            push, issue, head_rd, tag_pop;
    logic [33:0]     head_cmd;
    logic [27:0]     head_tag;
    assign cmd_full   = (cwp[AW] != crp[AW]) && (cwp[AW-1:0] == crp[AW-1:0]);
    assign cmd_empty  = cwp == crp;
    assign tag_full   = (twp[TW] != trp[TW]) && (twp[TW-1:0] == trp[TW-1:0]);
    assign tag_empty  = twp == trp;
    assign host_ready = !cmd_full;
    assign push       = host_valid && host_ready;
    assign head_cmd   = cmd_mem[crp[AW-1:0]];
    assign head_rd    = head_cmd[31];
    assign head_tag   = {head_cmd[33:32], head_cmd[2:0], head_cmd[29:17], head_cmd[12:3]};
    // tag_full is the registered state, so a same-cycle return never unblocks a read head
    assign issue      = !cmd_empty && ba_cmd_pm[head_cmd[2:0]] && (!head_rd || !tag_full);
    assign tag_pop    = read_data_valid && !tag_empty;
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[cwp[AW-1:0]] <= host_cmd;
            dat_mem[cwp[AW-1:0]] <= host_wdata;
        end
        if (issue && head_rd)
            tag_mem[twp[TW-1:0]] <= head_tag;
    end
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            cwp          <= '0;
            crp          <= '0;
            twp          <= '0;
            trp          <= '0;
            command      <= '0;
            write_data   <= '0;
            valid        <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_tag       <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (push)
                cwp <= cwp + (AW+1)'(1);
            if (issue)
                crp <= crp + (AW+1)'(1);
            if (issue && head_rd)
                twp <= twp + (TW+1)'(1);
            if (tag_pop)
                trp <= trp + (TW+1)'(1);
            valid        <= issue;
            command      <= issue ? head_cmd : '0;
            write_data   <= (issue && !head_rd) ? dat_mem[crp[AW-1:0]] : '0;
            rd_valid     <= read_data_valid;
            rd_data      <= read_data;
            rd_tag       <= tag_pop ? tag_mem[trp[TW-1:0]] : '0;
            rd_underflow <= rd_underflow || (read_data_valid && tag_empty);
        end
    end
`ifdef CMD_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            stat_wr_cnt    <= '0;
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (issue && !head_rd && stat_wr_cnt != 16'hFFFF)
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (issue && head_rd && stat_rd_cnt != 16'hFFFF)
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            if (!cmd_empty && !issue && stat_stall_cnt != 16'hFFFF)
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb_dram_cmd_issuer: directed self-checking bench for dram_cmd_issuer.
module tb_dram_cmd_issuer;
    logic         clk = 1'b0;
    logic         power_on_rst, host_valid, host_ready, valid;
    logic [33:0]  host_cmd, command;
    logic [127:0] host_wdata, write_data, read_data, rd_data;
    logic [7:0]   ba_cmd_pm;
    logic         read_data_valid, rd_valid, rd_underflow;
    logic [27:0]  rd_tag;
    int           n_run = 0, n_fail = 0, vcnt;
`ifdef CMD_ISSUE_STATS_EN
    logic [15:0]  stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif
    dram_cmd_issuer dut (
        .clk(clk), .power_on_rst(power_on_rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd), .host_wdata(host_wdata),
        .ba_cmd_pm(ba_cmd_pm), .command(command), .write_data(write_data), .valid(valid),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag), .rd_underflow(rd_underflow)
`ifdef CMD_ISSUE_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [33:0] mk_cmd(input logic rd, input logic [12:0] row, input logic [9:0] col, input logic [2:0] bank);
        return {2'b00, rd, 1'b0, row, 4'b0000, col, bank};
    endfunction
    function automatic logic [27:0] mk_tag(input logic [12:0] row, input logic [9:0] col, input logic [2:0] bank);
        return {2'b00, bank, row, col};
    endfunction
    initial begin
        power_on_rst = 1'b1; host_valid = 1'b0; host_cmd = '0; host_wdata = '0;
        ba_cmd_pm = 8'h00; read_data = '0; read_data_valid = 1'b0;
        step(); step();
        power_on_rst = 1'b0;
        chk("rst_ready", host_ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_command", command, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_underflow", rd_underflow, 0);
        // write then read of row 3 col 8 bank 0
        ba_cmd_pm = 8'hFF; host_valid = 1'b1;
        host_cmd = 34'h0_0006_0040; host_wdata = 128'hA5;
        step();
        chk("wr_not_yet", valid, 0);
        host_cmd = 34'h0_8006_0040; host_wdata = 128'hFF;
        step();
        host_valid = 1'b0;
        chk("wr_valid", valid, 1);
        chk("wr_cmd", command, 34'h0_0006_0040);
        chk("wr_data", write_data, 128'hA5);
        step();
        chk("rd_issue_valid", valid, 1);
        chk("rd_issue_cmd", command, 34'h0_8006_0040);
        chk("rd_issue_wdata", write_data, 0);
        step();
        chk("idle_valid", valid, 0);
        read_data_valid = 1'b1; read_data = 128'hA5;
        step();
        read_data_valid = 1'b0;
        chk("ret_valid", rd_valid, 1);
        chk("ret_tag", rd_tag, 28'h0000C08);
        chk("ret_data", rd_data, 128'hA5);
        chk("ret_no_underflow", rd_underflow, 0);
        step();
        chk("ret_done", rd_valid, 0);
        // head-of-line blocking
        ba_cmd_pm = 8'hFB; host_valid = 1'b1; host_cmd = mk_cmd(0, 1, 1, 2);
        step();
        host_cmd = mk_cmd(0, 2, 2, 0);
        step();
        host_valid = 1'b0;
        chk("hol_blk0", valid, 0);
        step(); chk("hol_blk1", valid, 0);
        step(); chk("hol_blk2", valid, 0);
        ba_cmd_pm = 8'hFF;
        step();
        chk("hol_first", command, mk_cmd(0, 1, 1, 2));
        step();
        chk("hol_second_v", valid, 1);
        chk("hol_second", command, mk_cmd(0, 2, 2, 0));
        step();
        chk("hol_done", valid, 0);
        // fill and drain
        ba_cmd_pm = 8'h00; host_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_cmd = mk_cmd(0, 13'(i + 100), 10'(i), 3'(i));
            host_wdata = 128'(i + 32'h1000);
            step();
        end
        host_valid = 1'b0;
        chk("fill_full", host_ready, 0);
        chk("fill_no_issue", valid, 0);
        ba_cmd_pm = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_valid", valid, 1);
            chk("drain_cmd", command, mk_cmd(0, 13'(i + 100), 10'(i), 3'(i)));
            chk("drain_data", write_data, 128'(i + 32'h1000));
        end
        step();
        chk("drain_done", valid, 0);
        chk("drain_ready", host_ready, 1);
        // tag FIFO full: 17 reads, no returns
        vcnt = 0; host_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            host_cmd = mk_cmd(1, 13'(i), 10'(i), 3'(i));
            step();
            vcnt += int'(valid);
        end
        host_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            vcnt += int'(valid);
        end
        chk("tag_issued16", 128'(vcnt), 16);
        chk("tag_stalled", valid, 0);
        read_data_valid = 1'b1;
        step();
        read_data_valid = 1'b0;
        chk("tag_same_cycle_blocked", valid, 0);
        chk("tag_ret_valid", rd_valid, 1);
        chk("tag_ret0", rd_tag, mk_tag(0, 0, 0));
        step();
        chk("tag_release_v", valid, 1);
        chk("tag_release_cmd", command, mk_cmd(1, 16, 16, 0));
        for (int j = 1; j <= 16; j++) begin
            read_data_valid = 1'b1;
            step();
            chk("tag_drain", rd_tag, mk_tag(13'(j), 10'(j), 3'(j)));
        end
        read_data_valid = 1'b0;
        step();
        chk("tag_no_underflow", rd_underflow, 0);
        // underflow
        read_data_valid = 1'b1;
        step();
        read_data_valid = 1'b0;
        chk("uf_rd_valid", rd_valid, 1);
        chk("uf_tag", rd_tag, 0);
        chk("uf_flag", rd_underflow, 1);
        step(); step();
        chk("uf_sticky", rd_underflow, 1);
        chk("uf_pulse_end", rd_valid, 0);
        // reset mid-operation discards a pending command
        ba_cmd_pm = 8'h00; host_valid = 1'b1; host_cmd = mk_cmd(0, 5, 5, 1);
        step();
        host_valid = 1'b0; power_on_rst = 1'b1;
        step();
        power_on_rst = 1'b0;
        chk("rst2_underflow", rd_underflow, 0);
        chk("rst2_ready", host_ready, 1);
        ba_cmd_pm = 8'hFF;
        step();
        chk("rst2_flushed", valid, 0);
        // 3 writes, 2 reads, 5 blocked cycles
        ba_cmd_pm = 8'h00; host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_cmd = mk_cmd(i >= 3, 13'(i), 10'(i), 3'(i));
            step();
        end
        host_valid = 1'b0;
        step();
        ba_cmd_pm = 8'hFF;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            vcnt += int'(valid);
        end
        chk("stats_issue5", 128'(vcnt), 5);
`ifdef CMD_ISSUE_STATS_EN
        chk("stat_wr", stat_wr_cnt, 3);
        chk("stat_rd", stat_rd_cnt, 2);
        chk("stat_stall", stat_stall_cnt, 5);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
